// File: rtl/sump_rsp_tx.sv
`default_nettype none
// ============================================================================
// Module   : sump_rsp_tx
// Brief    : SUMP/OLS response serializer (ID, metadata, sample words) onto a
//            valid/ready byte stream for the UART transmitter.
// Revision : 1.0
// ============================================================================
module sump_rsp_tx #(
  parameter logic [31:0] P_MEM_BYTES = 32'd4096,
  parameter logic [31:0] P_MAX_RATE  = 32'd100000000,
  parameter logic [7:0]  P_PROBES    = 8'd32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sft_rst_i,
  input  logic        id_i,
  input  logic        rd_meta_i,
  input  logic        xon_i,
  input  logic        xoff_i,
  input  logic        smpl_vld_i,
  output logic        smpl_rdy_o,
  input  logic [31:0] smpl_dat_i,
  input  logic [3:0]  grp_en_i,
  output logic        tx_vld_o,
  input  logic        tx_rdy_i,
  output logic [7:0]  tx_dat_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ID   = 2'd1,
    S_META = 2'd2,
    S_SMPL = 2'd3
  } state_t;

  localparam logic [4:0] C_ID_LAST   = 5'd3;
  localparam logic [4:0] C_META_LAST = 5'd21;

  state_t      r_state, w_state_nxt;
  logic        r_vld, w_vld_nxt;
  logic [7:0]  r_dat, w_dat_nxt;
  logic        r_paused, w_paused_nxt;
  logic [4:0]  r_idx, w_idx_nxt;
  logic [3:0]  r_mask, w_mask_nxt;
  logic [31:0] r_word, w_word_nxt;
  logic        r_none, w_none_nxt;
  logic        w_xfer;
  logic        w_last;
  logic [1:0]  w_grp;
  logic [1:0]  w_grp_in;
  logic [4:0]  w_idx_inc;

  function automatic logic [7:0] id_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    id_byte = 8'h31;
      2'd1:    id_byte = 8'h41;
      2'd2:    id_byte = 8'h4C;
      default: id_byte = 8'h53;
    endcase
  endfunction

  function automatic logic [7:0] meta_byte(input logic [4:0] idx);
    case (idx)
      5'd0:    meta_byte = 8'h01;
      5'd1:    meta_byte = 8'h6C;
      5'd2:    meta_byte = 8'h6F;
      5'd3:    meta_byte = 8'h67;
      5'd4:    meta_byte = 8'h49;
      5'd5:    meta_byte = 8'h50;
      5'd6:    meta_byte = 8'h00;
      5'd7:    meta_byte = 8'h21;
      5'd8:    meta_byte = P_MEM_BYTES[31:24];
      5'd9:    meta_byte = P_MEM_BYTES[23:16];
      5'd10:   meta_byte = P_MEM_BYTES[15:8];
      5'd11:   meta_byte = P_MEM_BYTES[7:0];
      5'd12:   meta_byte = 8'h23;
      5'd13:   meta_byte = P_MAX_RATE[31:24];
      5'd14:   meta_byte = P_MAX_RATE[23:16];
      5'd15:   meta_byte = P_MAX_RATE[15:8];
      5'd16:   meta_byte = P_MAX_RATE[7:0];
      5'd17:   meta_byte = 8'h40;
      5'd18:   meta_byte = P_PROBES;
      5'd19:   meta_byte = 8'h41;
      5'd20:   meta_byte = 8'h02;
      default: meta_byte = 8'h00;
    endcase
  endfunction

  function automatic logic [1:0] lowest(input logic [3:0] m);
    if (m[0])      lowest = 2'd0;
    else if (m[1]) lowest = 2'd1;
    else if (m[2]) lowest = 2'd2;
    else           lowest = 2'd3;
  endfunction

  function automatic logic [7:0] grp_byte(input logic [31:0] w, input logic [1:0] g);
    case (g)
      2'd0:    grp_byte = w[7:0];
      2'd1:    grp_byte = w[15:8];
      2'd2:    grp_byte = w[23:16];
      default: grp_byte = w[31:24];
    endcase
  endfunction

  assign w_xfer    = r_vld & tx_rdy_i;
  assign w_idx_inc = r_idx + 5'd1;
  assign w_grp     = lowest(r_mask);
  assign w_grp_in  = lowest(grp_en_i);

  // In SMPL, r_mask holds only the groups not yet loaded, so empty means last.
  always_comb begin
    w_last = 1'b0;
    case (r_state)
      S_ID:    w_last = (r_idx == C_ID_LAST);
      S_META:  w_last = (r_idx == C_META_LAST);
      S_SMPL:  w_last = (r_mask == 4'd0);
      default: w_last = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_vld_nxt    = r_vld;
    w_dat_nxt    = r_dat;
    w_idx_nxt    = r_idx;
    w_mask_nxt   = r_mask;
    w_word_nxt   = r_word;
    w_none_nxt   = r_none;
    w_paused_nxt = xoff_i ? 1'b1 : (xon_i ? 1'b0 : r_paused);
    smpl_rdy_o   = (r_state == S_IDLE) & ~id_i & ~rd_meta_i & ~sft_rst_i & ~rst_i;

    if (r_state == S_IDLE) begin
      if (id_i) begin
        w_state_nxt = S_ID;
        w_dat_nxt   = 8'h31;
        w_idx_nxt   = 5'd0;
        w_vld_nxt   = ~w_paused_nxt;
      end else if (rd_meta_i) begin
        w_state_nxt = S_META;
        w_dat_nxt   = 8'h01;
        w_idx_nxt   = 5'd0;
        w_vld_nxt   = ~w_paused_nxt;
      end else if (smpl_vld_i) begin
        w_state_nxt = S_SMPL;
        w_word_nxt  = smpl_dat_i;
        w_mask_nxt  = grp_en_i & ~(4'd1 << w_grp_in);
        w_none_nxt  = (grp_en_i == 4'd0);
        w_dat_nxt   = grp_byte(smpl_dat_i, w_grp_in);
        w_idx_nxt   = 5'd0;
        w_vld_nxt   = ~w_paused_nxt & (grp_en_i != 4'd0);
      end
    end else if ((r_state == S_SMPL) && r_none) begin
      w_state_nxt = S_IDLE;
      w_vld_nxt   = 1'b0;
    end else if (w_xfer) begin
      if (w_last) begin
        w_state_nxt = S_IDLE;
        w_vld_nxt   = 1'b0;
      end else begin
        // Pause is honoured here, at the byte boundary.
        w_idx_nxt = w_idx_inc;
        w_vld_nxt = ~w_paused_nxt;
        case (r_state)
          S_ID:   w_dat_nxt = id_byte(w_idx_inc[1:0]);
          S_META: w_dat_nxt = meta_byte(w_idx_inc);
          default: begin
            w_dat_nxt  = grp_byte(r_word, w_grp);
            w_mask_nxt = r_mask & ~(4'd1 << w_grp);
          end
        endcase
      end
    end else if (!r_vld) begin
      w_vld_nxt = ~w_paused_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i | sft_rst_i) begin
      r_state  <= S_IDLE;
      r_vld    <= 1'b0;
      r_dat    <= 8'h00;
      r_paused <= 1'b0;
      r_idx    <= 5'd0;
      r_mask   <= 4'd0;
      r_word   <= 32'd0;
      r_none   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_vld    <= w_vld_nxt;
      r_dat    <= w_dat_nxt;
      r_paused <= w_paused_nxt;
      r_idx    <= w_idx_nxt;
      r_mask   <= w_mask_nxt;
      r_word   <= w_word_nxt;
      r_none   <= w_none_nxt;
    end
  end

  assign tx_vld_o = r_vld;
  assign tx_dat_o = r_dat;
  assign busy_o   = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/sump_rsp_tx.md
Name: sump_rsp_tx

Overview:
- Response transmitter for the SUMP/OLS link. It is the outbound counterpart of the instruction decoder.
- Takes the decoder's ID, metadata and xon/xoff strobes, plus captured sample words from the sampler readout path.
- Serializes these into a byte stream on a valid/ready interface that feeds the UART transmitter.

Parameters:
- P_MEM_BYTES, 4096, sample memory size reported in metadata key 0x21 (32-bit).
- P_MAX_RATE, 100000000, max sample rate in Hz reported in metadata key 0x23 (32-bit).
- P_PROBES, 32, probe count reported in metadata key 0x40 (8-bit, must be <=255).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous reset, active-high.
- sft_rst_i  in  1  soft reset strobe from the instruction decoder.
- id_i  in  1  send-ID request strobe.
- rd_meta_i  in  1  send-metadata request strobe.
- xon_i  in  1  resume transmission strobe.
- xoff_i  in  1  pause transmission strobe.
- smpl_vld_i  in  1  sample word valid.
- smpl_rdy_o  out  1  sample word accepted when smpl_vld_i is also high.
- smpl_dat_i  in  32  sample word.
- grp_en_i  in  4  channel group enable; bit k enables smpl_dat_i[8k+7:8k].
- tx_vld_o  out  1  byte valid to the UART transmitter.
- tx_rdy_i  in  1  UART transmitter ready.
- tx_dat_o  out  8  byte to transmit.
- busy_o  out  1  a response is in progress.

Behaviour:
- Reset values (rst_i): state IDLE, tx_vld_o=0, tx_dat_o=0x00, busy_o=0, smpl_rdy_o=0, paused=0, byte index=0.
- sft_rst_i: identical effect to rst_i. It is the only case in which tx_vld_o may drop without a handshake.
- States: IDLE, ID, META, SMPL.
- busy_o = (state != IDLE).
- smpl_rdy_o = (state == IDLE) & ~id_i & ~rd_meta_i & ~sft_rst_i.
- Request priority in IDLE: id_i > rd_meta_i > smpl_vld_i. A lower-priority request in the same cycle is dropped (strobes) or stays pending (smpl_vld_i, not accepted).
- Requests arriving while not in IDLE are ignored.
- Accepting a request:
  - tx_dat_o is loaded with the first byte.
  - tx_vld_o rises the next cycle unless paused.
  - grp_en_i and smpl_dat_i are latched on accept. Later changes do not affect the word in flight.
- Handshake: a byte transfers on tx_vld_o & tx_rdy_i.
  - Once high, tx_vld_o and tx_dat_o hold stable until that transfer.
  - On a transfer that is not the last byte, the next byte is presented the following cycle with tx_vld_o kept high, giving 1 byte/cycle throughput.
  - On the last byte's transfer, the block returns to IDLE the next cycle with tx_vld_o=0 and busy_o=0. A new request can be accepted in that cycle.
- ID sequence, 4 bytes: 0x31 0x41 0x4C 0x53 ("1ALS").
- META sequence, 22 bytes:
  - 0x01, then 'l' 'o' 'g' 'I' 'P' (0x6C 0x6F 0x67 0x49 0x50), then 0x00.
  - 0x21, then P_MEM_BYTES, 4 bytes MSB first.
  - 0x23, then P_MAX_RATE, 4 bytes MSB first.
  - 0x40, then P_PROBES[7:0].
  - 0x41, then 0x02.
  - 0x00 (end).
- SMPL sequence:
  - Enabled groups are sent in ascending order (group 0 first, LSB-first). Disabled groups are skipped with no bubble cycles.
  - Latched mask 0000: no byte is sent; state returns to IDLE the next cycle.
  - Mask 1111: 4 bytes.
- Byte index counter: 5 bits. It resets to 0 on every accept and never wraps within a sequence.
- Flow control:
  - xoff_i sets paused; xon_i clears it.
  - Both in the same cycle: xoff_i wins.
  - Pause takes effect only at byte boundaries. A byte already presented (tx_vld_o=1) completes its transfer. After that, tx_vld_o stays 0 while paused, and the sequence resumes at the next byte the cycle after xon_i.
  - Requests are still accepted while paused; they are queued as state, and no bytes are emitted until xon_i.
  - xon_i/xoff_i act in any state. paused is cleared by rst_i and sft_rst_i.

Test Plan:
- ID: rst_i, then id_i pulse with tx_rdy_i=1 → tx_vld_o high for 4 consecutive cycles with bytes 0x31,0x41,0x4C,0x53; busy_o=0 on the following cycle.
- Metadata with backpressure: rd_meta_i, tx_rdy_i toggling 1,0,1,0 → exactly 22 bytes in table order; tx_dat_o stable during every ready-low cycle; key 0x21 bytes 0x00 0x00 0x10 0x00.
- Sample masking: smpl_dat_i=0xDDCCBBAA, grp_en_i=4'b1010, smpl_vld_i=1 → smpl_rdy_o=1 for one cycle, bytes 0xBB then 0xDD back-to-back, no bubble; then mask 0000 → accepted, no bytes, busy_o high for 1 cycle only.
- Priority/ignore: id_i and rd_meta_i in the same cycle → only the 4-byte ID is sent; rd_meta_i pulse mid-ID → ignored; smpl_vld_i held during ID → accepted in the first IDLE cycle after ID.
- Flow control: xoff_i during META after byte 3 is presented → byte 3 completes, tx_vld_o=0 for 10 cycles; xon_i → byte 4 (0x67) presented the next cycle and the remaining sequence completes; xon_i & xoff_i together → stays paused.
- Reset mid-operation: sft_rst_i while tx_vld_o=1 in byte 10 of META → next cycle tx_vld_o=0, busy_o=0, paused=0; a subsequent id_i yields the full "1ALS" sequence. Repeat with rst_i.
